// File: rtl/gcd_controller_if.sv
// rtl/gcd_controller_if.sv - host/DataPath signal bundle for the GCD control unit
interface gcd_controller_if #(
    parameter int CNT_W = 17
);
    // Host request and DataPath status flags
    logic             start;
    logic             ZEQ_Flag;
    logic             LEQ_Flag;

    // DataPath control strobes
    logic             SelectXY;
    logic             loadXR;
    logic             loadYR;
    logic             subFlag;
    logic             swapFlag;

    // Host status
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] iter_count;

    // Controller side: owns every strobe and status output
    modport master (
        input  start,
        input  ZEQ_Flag,
        input  LEQ_Flag,
        output SelectXY,
        output loadXR,
        output loadYR,
        output subFlag,
        output swapFlag,
        output busy,
        output done,
        output error,
        output iter_count
    );

    // Host/DataPath side: drives the request and the flags
    modport slave (
        output start,
        output ZEQ_Flag,
        output LEQ_Flag,
        input  SelectXY,
        input  loadXR,
        input  loadYR,
        input  subFlag,
        input  swapFlag,
        input  busy,
        input  done,
        input  error,
        input  iter_count
    );
endinterface

// File: rtl/gcd_controller.sv
// rtl/gcd_controller.sv - Moore control unit for the subtract/swap GCD DataPath
module gcd_controller #(
    parameter int CNT_W    = 17,
    parameter int MAX_ITER = 70000
) (
    input  logic               clk,
    input  logic               rst,
    gcd_controller_if.master   bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        SWAP  = 3'd3,
        SUB   = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] MaxIter = CNT_W'(MAX_ITER);

    state_t           state;
    state_t           nextState;
    logic [CNT_W-1:0] iterCount;

    logic selectXY;
    logic loadXR;
    logic loadYR;
    logic subFlag;
    logic swapFlag;
    logic busy;
    logic done;
    logic error;

    // State register; reset returns to IDLE from anywhere, including mid-run
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Operation counter: cleared on LOAD, bumped on each swap/sub, held otherwise.
    // The CHECK state never issues an op once the limit is reached, so the
    // saturation guard only protects against a counter wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            iterCount <= '0;
        end else begin
            case (state)
                LOAD:      iterCount <= '0;
                SWAP, SUB: begin
                    if (iterCount != MaxIter) begin
                        iterCount <= iterCount + 1'b1;
                    end
                end
                default:   iterCount <= iterCount;
            endcase
        end
    end

    // Next-state decode; flag priority in CHECK is ZEQ, then timeout, then LEQ
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    nextState = LOAD;
                end
            end
            LOAD:  nextState = CHECK;
            CHECK: begin
                if (bus.ZEQ_Flag) begin
                    nextState = DONE;
                end else if (iterCount == MaxIter) begin
                    nextState = ERR;
                end else if (bus.LEQ_Flag) begin
                    nextState = SWAP;
                end else begin
                    nextState = SUB;
                end
            end
            SWAP:    nextState = CHECK;
            SUB:     nextState = CHECK;
            DONE:    nextState = IDLE;
            ERR:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Output decode purely from the registered state (no start-to-output path)
    always_comb begin
        selectXY = 1'b0;
        loadXR   = 1'b0;
        loadYR   = 1'b0;
        subFlag  = 1'b0;
        swapFlag = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        case (state)
            LOAD: begin
                selectXY = 1'b1;
                loadXR   = 1'b1;
                loadYR   = 1'b1;
                busy     = 1'b1;
            end
            CHECK: begin
                busy     = 1'b1;
            end
            SWAP: begin
                swapFlag = 1'b1;
                loadXR   = 1'b1;
                loadYR   = 1'b1;
                busy     = 1'b1;
            end
            SUB: begin
                subFlag  = 1'b1;
                loadXR   = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                done     = 1'b1;
            end
            ERR: begin
                error    = 1'b1;
            end
            default: begin
                busy     = 1'b0;
            end
        endcase
    end

    assign bus.SelectXY   = selectXY;
    assign bus.loadXR     = loadXR;
    assign bus.loadYR     = loadYR;
    assign bus.subFlag    = subFlag;
    assign bus.swapFlag   = swapFlag;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.error      = error;
    assign bus.iter_count = iterCount;

endmodule
